// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for mem_bus_arbiter: FSM state, grant id, error read pattern.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CPU_XFER = 2'd1,
        ST_LD_XFER  = 2'd2,
        ST_DONE     = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_LD  = 1'b1
    } gnt_id_t;

    localparam int MAX_DATA_W = 64;
    localparam logic [MAX_DATA_W-1:0] ERR_DATA = '1;
    localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Memory-ack watchdog: counts transfer cycles, flags the TMO_CYC-th cycle.
module arb_timeout_cnt
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TMO_CYC = 255
) (
    input  logic clk,
    input  logic rst_b,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(TMO_CYC - 1);

    logic [TMO_CNT_W-1:0] r_cnt;

    assign o_expired = i_en && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU / loader) single-memory arbiter with ack timeout.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is CPU priority.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    arb_state_t        r_state;
    gnt_id_t           r_gnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cap;
    logic              r_mem_req;
    logic              r_cpu_ack;
    logic              r_ld_ack;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_ld_rdata;
    logic              r_bus_err;

    logic w_cpu_req;
    logic w_in_xfer;
    logic w_ack_busy;
    logic w_pick_ld;
    logic w_expired;

    assign w_cpu_req  = cpu_read | cpu_write;
    assign w_in_xfer  = (r_state == ST_CPU_XFER) || (r_state == ST_LD_XFER);
    // The ack cycle still sees the requester's held request; it must not re-grant it.
    assign w_ack_busy = r_cpu_ack | r_ld_ack;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    gnt_id_t r_last;
    assign w_pick_ld = ld_req && (!w_cpu_req || (r_last == GNT_CPU));
`else
    assign w_pick_ld = ld_req && !w_cpu_req;
`endif

    arb_timeout_cnt #(.TMO_CYC(TMO_CYC)) u_tmo (
        .clk       (clk),
        .rst_b     (rst_b),
        .i_clr     (!w_in_xfer),
        .i_en      (w_in_xfer),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= ST_IDLE;
            r_gnt       <= GNT_CPU;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cap       <= '0;
            r_mem_req   <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_ld_ack    <= 1'b0;
            r_cpu_rdata <= '0;
            r_ld_rdata  <= '0;
            r_bus_err   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last      <= GNT_LD;
`endif
        end else begin
            r_cpu_ack   <= 1'b0;
            r_ld_ack    <= 1'b0;
            r_cpu_rdata <= '0;
            r_ld_rdata  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_ack_busy && (w_cpu_req || ld_req)) begin
                        r_mem_req <= 1'b1;
                        if (w_pick_ld) begin
                            r_gnt   <= GNT_LD;
                            r_we    <= ld_we;
                            r_addr  <= ld_addr;
                            r_wdata <= ld_wdata;
                            r_state <= ST_LD_XFER;
                        end else begin
                            r_gnt   <= GNT_CPU;
                            r_we    <= cpu_write;
                            r_addr  <= cpu_addr;
                            r_wdata <= cpu_wdata;
                            r_state <= ST_CPU_XFER;
                        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        r_last <= w_pick_ld ? GNT_LD : GNT_CPU;
`endif
                    end
                end
                ST_CPU_XFER, ST_LD_XFER: begin
                    if (mem_ack) begin
                        r_cap     <= mem_rdata;
                        r_mem_req <= 1'b0;
                        r_state   <= ST_DONE;
                    end else if (w_expired) begin
                        r_cap     <= ERR_DATA[DATA_W-1:0];
                        r_bus_err <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Writes return zero even when they timed out.
                    if (r_gnt == GNT_CPU) begin
                        r_cpu_ack   <= 1'b1;
                        r_cpu_rdata <= r_we ? '0 : r_cap;
                    end else begin
                        r_ld_ack    <= 1'b1;
                        r_ld_rdata  <= r_we ? '0 : r_cap;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign cpu_ack   = r_cpu_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign ld_ack    = r_ld_ack;
    assign ld_rdata  = r_ld_rdata;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic against a
// transaction-timing model; a second instance with a 4-cycle timeout never sees mem_ack.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int TMO  = 12;
    localparam int TMO4 = 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          rst_b4 = 1'b0;
    logic          cpu_read = 1'b0, cpu_write = 1'b0, ld_req = 1'b0, ld_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0, ld_addr = '0;
    logic [DW-1:0] cpu_wdata = '0, ld_wdata = '0, mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          zero1 = 1'b0;
    logic [DW-1:0] zero_d = '0;

    wire [DW-1:0] cpu_rdata, ld_rdata, mem_wdata, t_cpu_rdata, t_ld_rdata, t_mem_wdata;
    wire [AW-1:0] mem_addr, t_mem_addr;
    wire          cpu_ack, ld_ack, mem_req, mem_we, bus_err;
    wire          t_cpu_ack, t_ld_ack, t_mem_req, t_mem_we, t_bus_err;

    mem_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_b(rst_b),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_ack(ld_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );

    mem_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TMO_CYC(TMO4)) dut4 (
        .clk(clk), .rst_b(rst_b4),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(t_cpu_rdata), .cpu_ack(t_cpu_ack),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(t_ld_rdata), .ld_ack(t_ld_ack),
        .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
        .mem_rdata(zero_d), .mem_ack(zero1), .bus_err(t_bus_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk1(input string nm, input logic a, input logic e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic chkd(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic chki(input string nm, input int a, input int e);
        n_vec++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    // Model: one transaction in flight; grant edge t_g, completion edge t_e,
    // ack visible after edge t_e+1, next grant possible from edge t_e+3.
    int            m_n, m_tg, m_te;
    bit            m_busy, m_ended, m_owner, m_we, m_err, m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_res;

    task automatic model_reset();
        m_n = 0; m_tg = 0; m_te = 0;
        m_busy = 0; m_ended = 0; m_owner = 0; m_we = 0; m_err = 0; m_last = 1;
        m_addr = '0; m_wdata = '0; m_res = '0;
    endtask

    task automatic model_step();
        bit creq, pick_ld;
        m_n++;
        if (m_busy && !m_ended) begin
            if (mem_ack) begin
                m_ended = 1; m_te = m_n; m_res = m_we ? '0 : mem_rdata;
            end else if (m_n - m_tg == TMO) begin
                m_ended = 1; m_te = m_n; m_res = m_we ? '0 : {DW{1'b1}}; m_err = 1;
            end
        end
        if (!m_busy || (m_ended && m_n >= m_te + 3)) begin
            m_busy = 0;
            creq = cpu_read | cpu_write;
            if (creq || ld_req) begin
                pick_ld = ld_req && (!creq || (RR && !m_last));
                m_owner = pick_ld; m_last = pick_ld;
                m_we    = pick_ld ? ld_we : cpu_write;
                m_addr  = pick_ld ? ld_addr : cpu_addr;
                m_wdata = pick_ld ? ld_wdata : cpu_wdata;
                m_busy = 1; m_ended = 0; m_tg = m_n;
            end
        end
    endtask

    initial begin : compare
        bit e_ack;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_b) model_reset();
            e_ack = m_busy && m_ended && (m_n == m_te + 1);
            chk1("mem_req",   mem_req,   m_busy && !m_ended);
            chk1("mem_we",    mem_we,    m_we);
            chkd("mem_addr",  mem_addr,  m_addr);
            chkd("mem_wdata", mem_wdata, m_wdata);
            chk1("cpu_ack",   cpu_ack,   e_ack && !m_owner);
            chkd("cpu_rdata", cpu_rdata, (e_ack && !m_owner) ? m_res : '0);
            chk1("ld_ack",    ld_ack,    e_ack && m_owner);
            chkd("ld_rdata",  ld_rdata,  (e_ack && m_owner) ? m_res : '0);
            chk1("bus_err",   bus_err,   m_err);
            if (rst_b) model_step();
        end
    end

    // Memory responder: 0/3 random acks (dense/sparse), 1 ack after mem_delay, 2 never.
    int            mem_mode = 1, mem_delay = 0, mem_cnt = 0;
    logic [DW-1:0] mem_val = '0;

    initial begin : responder
        forever begin
            @(posedge clk); #1;
            case (mem_mode)
                1: begin
                    if (mem_req) begin
                        mem_ack = (mem_cnt == mem_delay);
                        mem_cnt++;
                    end else begin
                        mem_ack = 1'b0;
                        mem_cnt = 0;
                    end
                    mem_rdata = mem_val;
                end
                2: begin mem_ack = 1'b0; mem_rdata = DW'($urandom); end
                3: begin mem_ack = ($urandom_range(0, 15) == 0); mem_rdata = DW'($urandom); end
                default: begin mem_ack = ($urandom_range(0, 3) == 0); mem_rdata = DW'($urandom); end
            endcase
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_ack(output int who, output int cyc);
        who = -1; cyc = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (cpu_ack || ld_ack) begin
                who = ld_ack ? 1 : 0; cyc = c;
                break;
            end
        end
        if (who < 0) begin
            n_vec++; n_err++;
            $display("FAIL ack_wait: no ack within 60 cycles");
        end
    endtask

    int   who, cyc, cnt_a, cnt_b, cnt_c, k;
    logic cs, ls, seen;

    initial begin : main
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_cpu_ack", cpu_ack, 1'b0);
        chk1("rst_ld_ack",  ld_ack,  1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        chkd("rst_mem_addr", mem_addr, 16'h0000);
        tick(); rst_b = 1'b1;
        idle(2);

        // CPU read, ack in first transfer cycle
        mem_mode = 1; mem_delay = 0; mem_val = 16'h1234;
        cpu_read = 1'b1; cpu_addr = 16'h0040;
        wait_ack(who, cyc);
        chki("t028_who", who, 0);
        chki("t028_latency", cyc, 3);
        chkd("t028_rdata", cpu_rdata, 16'h1234);
        chk1("t028_ld_ack", ld_ack, 1'b0);
        chkd("t028_addr", mem_addr, 16'h0040);
        tick(); cpu_read = 1'b0;
        idle(3);

        // Simultaneous requests, held across two arbitrations
        cpu_write = 1'b1; cpu_addr = 16'h0101; cpu_wdata = 16'hA5A5;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0202;
        wait_ack(who, cyc);
        chki("t029_first", who, 0);
        chk1("t029_we", mem_we, 1'b1);
        chkd("t029_addr", mem_addr, 16'h0101);
        chkd("t029_wr_rdata", cpu_rdata, 16'h0000);
        wait_ack(who, cyc);
        chki("t029_second", who, RR ? 1 : 0);
        tick(); cpu_write = 1'b0;
        if (!RR) begin
            wait_ack(who, cyc);
            chki("t029_third", who, 1);
            chkd("t029_ld_addr", mem_addr, 16'h0202);
            tick();
        end
        ld_req = 1'b0;
        idle(3);

        // LD write with 10-cycle-delayed ack
        mem_delay = 10;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h01FF; ld_wdata = 16'hBEEF;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (mem_req) begin
                cnt_a++;
                if (mem_addr !== 16'h01FF || mem_wdata !== 16'hBEEF || mem_we !== 1'b1) cnt_c++;
            end
            if (ld_ack) begin
                cnt_b++;
                chkd("t030_rdata", ld_rdata, 16'h0000);
            end
            seen = ld_ack;
            tick();
            if (seen) ld_req = 1'b0;
        end
        chki("t030_req_cycles", cnt_a, 11);
        chki("t030_unstable", cnt_c, 0);
        chki("t030_acks", cnt_b, 1);
        idle(3);

        // Timeout on the 4-cycle instance (main one times out at 12)
        rst_b4 = 1'b1; mem_mode = 2;
        tick();
        cpu_read = 1'b1; cpu_addr = 16'h0123;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (cnt_b == 0 && t_mem_req) cnt_a++;
            if (t_cpu_ack && cnt_b == 0) begin
                chkd("t031_rdata", t_cpu_rdata, 16'hFFFF);
                chk1("t031_err", t_bus_err, 1'b1);
                chk1("t031_ld_ack", t_ld_ack, 1'b0);
            end
            if (t_cpu_ack) cnt_b++;
            if (cpu_ack) begin
                cnt_c++;
                chkd("t031_main_rdata", cpu_rdata, 16'hFFFF);
                chk1("t031_main_err", bus_err, 1'b1);
            end
            seen = cpu_ack;
            tick();
            if (seen) cpu_read = 1'b0;
        end
        chki("t031_req_cycles", cnt_a, 4);
        chk1("t031_acked", cnt_b > 0, 1'b1);
        chki("t031_main_acks", cnt_c, 1);
        rst_b4 = 1'b0;
        idle(3);

        // Reset during LD transfer
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0077;
        idle(3);
        @(negedge clk);
        chk1("t032_in_xfer", mem_req, 1'b1);
        #2 rst_b = 1'b0;
        #1;
        chk1("t032_mem_req", mem_req, 1'b0);
        chk1("t032_ld_ack", ld_ack, 1'b0);
        chk1("t032_bus_err", bus_err, 1'b0);
        chkd("t032_addr", mem_addr, 16'h0000);
        ld_req = 1'b0;
        @(negedge clk);
        tick(); rst_b = 1'b1;
        cnt_a = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (cpu_ack || ld_ack) cnt_a++;
            tick();
        end
        chki("t032_no_ack", cnt_a, 0);
        mem_mode = 1; mem_delay = 2; mem_val = 16'h5A5A;
        ld_req = 1'b1; ld_addr = 16'h0078;
        wait_ack(who, cyc);
        chki("t032_who", who, 1);
        chkd("t032_rdata", ld_rdata, 16'h5A5A);
        tick(); ld_req = 1'b0;
        idle(3);

        // CPU read dropped right after grant
        mem_delay = 1; mem_val = 16'hC0DE;
        cpu_read = 1'b1; cpu_addr = 16'h0200;
        tick(); cpu_read = 1'b0;
        cnt_a = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (cpu_ack) begin
                cnt_a++;
                chkd("t033_rdata", cpu_rdata, 16'hC0DE);
            end
            tick();
        end
        chki("t033_acks", cnt_a, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); cs = cpu_ack; ls = ld_ack;
            tick();
            if (i % 400 == 0) mem_mode = ($urandom_range(0, 1) == 0) ? 0 : 3;
            if (cpu_read || cpu_write) begin
                if ((cs && $urandom_range(0, 3) != 0) || $urandom_range(0, 23) == 0) begin
                    cpu_read = 1'b0; cpu_write = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
                end
            end else if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, 4);
                cpu_read = (k < 2) || (k == 4); cpu_write = (k >= 2);
                cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
            end
            if (ld_req) begin
                if ((ls && $urandom_range(0, 3) != 0) || $urandom_range(0, 23) == 0) begin
                    ld_req = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    ld_addr = AW'($urandom); ld_wdata = DW'($urandom);
                end
            end else if ($urandom_range(0, 2) == 0) begin
                ld_req = 1'b1; ld_we = $urandom_range(0, 1) == 1;
                ld_addr = AW'($urandom); ld_wdata = DW'($urandom);
            end
        end
        cpu_read = 1'b0; cpu_write = 1'b0; ld_req = 1'b0;
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: DATA_W, 16, data bus width.
REQ-002 Parameter: ADDR_W, 16, address width.
REQ-003 Parameter: TMO_CYC, 255, memory-ack timeout in cycles (1..65535).
REQ-004 Single clock; reset asynchronous, active-low; ports clk, rst_b.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_b  in  1  async active-low reset.
REQ-007 cpu_read / cpu_write  in  1 each  CPU access request, held until cpu_ack.
REQ-008 cpu_addr  in  ADDR_W  CPU address; cpu_wdata  in  DATA_W  CPU write data.
REQ-009 cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1; cpu_ack  out  1  one-cycle completion pulse.
REQ-010 ld_req, ld_we  in  1 each  loader/debug request and write-enable, held until ld_ack.
REQ-011 ld_addr  in  ADDR_W; ld_wdata  in  DATA_W; ld_rdata  out  DATA_W; ld_ack  out  1.
REQ-012 mem_req, mem_we  out  1 each; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W; mem_ack  in  1.
REQ-013 bus_err  out  1  sticky timeout flag, cleared only by reset.

Function
REQ-014 FSM states: IDLE, CPU_XFER, LD_XFER, DONE.
- IDLE: sample requests; on grant, latch addr/wdata/we into registers; next state CPU_XFER or LD_XFER.
- XFER: mem_req=1 with latched signals until mem_ack; capture mem_rdata on the mem_ack cycle; -> DONE.
- DONE: pulse the granted requester's ack for exactly one cycle, drive its rdata from the capture register; -> IDLE.
REQ-015 All mem_*, *_ack and *_rdata outputs are registered; minimum latency request-sample to ack = 3 cycles with mem_ack returned in the first XFER cycle.
REQ-016 cpu_read and cpu_write both high: treated as write.
REQ-017 Requester dropping its request mid-transfer: transfer still completes, ack still pulsed.
REQ-018 Requests are not re-sampled in DONE; a request still held after ack is treated as new in the following IDLE cycle.
REQ-019 Timeout counter starts at 0 on XFER entry; on reaching TMO_CYC without mem_ack: drop mem_req, set bus_err, return rdata all-ones, -> DONE (ack still pulsed).
REQ-020 mem_ack outside XFER is ignored.
REQ-021 Write transfers: rdata output = 0 during ack.

Reset
REQ-022 rst_b low: state IDLE; all outputs 0; timeout counter, latched registers and bus_err 0; last-grant pointer = loader (CPU wins first tie).
REQ-023 Reset mid-transfer aborts immediately without an ack; the memory side sees mem_req fall asynchronously.

Configuration
REQ-024 Macro MEM_ARB_ROUND_ROBIN_EN defined: simultaneous requests in IDLE go to the requester not granted last.
REQ-025 Macro undefined: CPU always wins ties; the last-grant pointer is not implemented.

Structure
REQ-026 Shared package holds the FSM state enum (2 bits), the grant-id encoding (0=CPU, 1=LD), and the all-ones error-data constant.
REQ-027 One sub-module, arb_timeout_cnt: clear/enable inputs and an expired output; everything else stays in one module.

Verification
REQ-028 CPU read addr 0x0040, mem_ack next cycle with rdata 0x1234 -> cpu_ack at cycle 3, cpu_rdata=0x1234, ld_ack=0.
REQ-029 cpu_write and ld_req high in the same cycle, twice in a row -> CPU first, then LD with RR_EN; without RR_EN, CPU both times until its request is removed.
REQ-030 LD write addr 0x01FF data 0xBEEF with mem_ack delayed 10 cycles -> mem_addr/mem_wdata stable all 10 cycles; ld_ack once.
REQ-031 TMO_CYC=4, mem_ack never returned -> mem_req high 4 cycles, bus_err=1, cpu_ack with rdata 0xFFFF.
REQ-032 rst_b pulsed low during LD_XFER -> all outputs 0 the same cycle, no ack; next request is serviced normally.
REQ-033 cpu_read deasserted the cycle after grant -> transfer completes and cpu_ack still pulses once.
